// File: rtl/caravel_uart_wb_master.sv
// rtl/caravel_uart_wb_master.sv - UART command parser driving single Wishbone master cycles
`timescale 1ns/1ps
module caravel_uart_wb_master #(
    parameter int BAUD_DIV   = 15,
    parameter int WB_TIMEOUT = 1024
) (
    input  logic        app_clk,
    input  logic        line_reset_n,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);
    localparam logic [15:0] BIT_LAST = 16'(16 * (BAUD_DIV + 1) - 1);
    localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV);
    localparam logic [15:0] TMO_LAST = 16'(WB_TIMEOUT - 1);

    localparam logic [3:0] P_IDLE = 4'd0, P_CMD1 = 4'd1, P_CMD2 = 4'd2, P_SP1 = 4'd3, P_ADDR = 4'd4;
    localparam logic [3:0] P_SP2 = 4'd5, P_DATA = 4'd6, P_EXEC = 4'd7, P_RESP = 4'd8, P_DISC = 4'd9;
    localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
    localparam logic [1:0] K_BANNER = 2'd0, K_OK = 2'd1, K_ERR = 2'd2, K_READ = 2'd3;

    // Messages left-aligned in 16 chars so char i sits at bits [8*(15-i) +: 8]
    localparam logic [127:0] BANNER = {"UART2WB ready\n", 16'h0};
    localparam logic [127:0] OK_MSG = {"cmd success\n", 32'h0};
    localparam logic [127:0] ER_MSG = {"error\n", 80'h0};

    // ---------------- UART receiver (16x oversampled) ----------------
    logic       rxd_m_q, rxd_s_q, rx_vld_q;
    logic [1:0] rx_st_q;
    logic [15:0] rx_div_q;
    logic [3:0] rx_tick_q;
    logic [2:0] rx_bit_q;
    logic [7:0] rx_sh_q;
    logic       rx_tick, rx_mid;

    assign rx_tick = (rx_div_q == DIV_LAST);
    assign rx_mid  = rx_tick && (rx_tick_q == 4'd7);

    always_ff @(posedge app_clk or negedge line_reset_n) begin
        if (!line_reset_n) begin
            rxd_m_q <= 1'b1; rxd_s_q <= 1'b1; rx_vld_q <= 1'b0; rx_st_q <= R_IDLE;
            rx_div_q <= '0; rx_tick_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
        end else begin
            rxd_m_q  <= uart_rxd;
            rxd_s_q  <= rxd_m_q;
            rx_vld_q <= 1'b0;
            if (rx_st_q == R_IDLE) begin
                rx_div_q  <= '0;
                rx_tick_q <= '0;
                if (!rxd_s_q) rx_st_q <= R_START;
            end else begin
                rx_div_q <= rx_tick ? 16'd0 : rx_div_q + 16'd1;
                if (rx_tick) rx_tick_q <= rx_tick_q + 4'd1;
                if (rx_mid) begin
                    case (rx_st_q)
                        R_START: begin rx_st_q <= rxd_s_q ? R_IDLE : R_DATA; rx_bit_q <= '0; end
                        R_DATA: begin
                            rx_sh_q  <= {rxd_s_q, rx_sh_q[7:1]};
                            rx_bit_q <= rx_bit_q + 3'd1;
                            if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
                        end
                        default: begin rx_st_q <= R_IDLE; rx_vld_q <= rxd_s_q; end
                    endcase
                end
            end
        end
    end

    // ---------------- 16-byte RX FIFO ----------------
    logic [7:0] fifo_mem [16];
    logic [3:0] wr_ptr_q, rd_ptr_q;
    logic [4:0] cnt_q;
    logic       push, pop, rx_drop;
    logic [7:0] ch, lc;

    assign push    = rx_vld_q && (cnt_q != 5'd16);
    assign rx_drop = rx_vld_q && (cnt_q == 5'd16);
    assign ch      = fifo_mem[rd_ptr_q];
    assign lc      = ch | 8'h20;

    always_ff @(posedge app_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= rx_sh_q;
    end

    always_ff @(posedge app_clk or negedge line_reset_n) begin
        if (!line_reset_n) begin
            wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 4'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 4'd1;
            cnt_q <= cnt_q + {4'd0, push} - {4'd0, pop};
        end
    end

    // ---------------- command parser / WB master ----------------
    logic [3:0]  st_q, st_d, ndig_q, ndig_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  kind_q, kind_d;
    logic        wr_q, wr_d, lerr_q, lerr_d, cyc_q, cyc_d;
    logic        is_term, is_dig, is_hex, bad, go;
    logic [3:0]  hex_val;
    logic        msg_busy_q;

    assign is_term = (ch == 8'h0A) || (ch == 8'h0D);
    assign is_dig  = (ch >= 8'h30) && (ch <= 8'h39);
    assign is_hex  = is_dig || ((lc >= 8'h61) && (lc <= 8'h66));
    assign hex_val = is_dig ? ch[3:0] : lc[3:0] + 4'd9;
    assign pop     = (cnt_q != 5'd0) && (st_q != P_EXEC) && (st_q != P_RESP);

    always_comb begin
        st_d = st_q; ndig_d = ndig_q; adr_d = adr_q; dat_d = dat_q; rdat_d = rdat_q;
        tmo_d = tmo_q; kind_d = kind_q; wr_d = wr_q; cyc_d = cyc_q;
        lerr_d = lerr_q | rx_drop;
        bad = 1'b0; go = 1'b0;
        if (pop) begin
            case (st_q)
                P_IDLE: if (!is_term) begin
                    if (lc == 8'h77)      begin wr_d = 1'b1; st_d = P_CMD1; end
                    else if (lc == 8'h72) begin wr_d = 1'b0; st_d = P_CMD1; end
                    else bad = 1'b1;
                end
                P_CMD1: if (lc == 8'h6D) st_d = P_CMD2; else bad = 1'b1;
                P_CMD2: if (ch == 8'h20) begin
                    st_d = P_SP1; adr_d = '0; dat_d = '0; ndig_d = '0;
                end else bad = 1'b1;
                P_SP1, P_ADDR: begin
                    if (is_hex && ndig_q != 4'd8) begin
                        adr_d = {adr_q[27:0], hex_val}; ndig_d = ndig_q + 4'd1; st_d = P_ADDR;
                    end else if (st_q == P_ADDR && ch == 8'h20 && wr_q) begin
                        st_d = P_SP2; ndig_d = '0;
                    end else if (st_q == P_ADDR && is_term && !wr_q) go = 1'b1;
                    else bad = 1'b1;
                end
                P_SP2, P_DATA: begin
                    if (is_hex && ndig_q != 4'd8) begin
                        dat_d = {dat_q[27:0], hex_val}; ndig_d = ndig_q + 4'd1; st_d = P_DATA;
                    end else if (st_q == P_DATA && is_term) go = 1'b1;
                    else bad = 1'b1;
                end
                P_DISC: if (is_term) begin st_d = P_RESP; kind_d = K_ERR; lerr_d = 1'b0; end
                default: ;
            endcase
        end
        // An illegal terminator ends the line right away; anything else discards to the terminator
        if (bad) begin
            st_d = is_term ? P_RESP : P_DISC;
            kind_d = K_ERR;
            if (is_term) lerr_d = 1'b0;
        end
        if (go) begin
            lerr_d = 1'b0;
            if (lerr_q) begin st_d = P_RESP; kind_d = K_ERR; end
            else begin st_d = P_EXEC; cyc_d = 1'b1; tmo_d = '0; end
        end
        case (st_q)
            P_EXEC: begin
                if (wbm_ack_i) begin
                    cyc_d = 1'b0; st_d = P_RESP; rdat_d = wbm_dat_i; kind_d = wr_q ? K_OK : K_READ;
                end else if (wbm_err_i || tmo_q == TMO_LAST) begin
                    cyc_d = 1'b0; st_d = P_RESP; kind_d = K_ERR;
                end else tmo_d = tmo_q + 16'd1;
            end
            P_RESP: if (!msg_busy_q) st_d = P_IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge app_clk or negedge line_reset_n) begin
        if (!line_reset_n) begin
            st_q <= P_IDLE; ndig_q <= '0; adr_q <= '0; dat_q <= '0; rdat_q <= '0;
            tmo_q <= '0; kind_q <= K_ERR; wr_q <= 1'b0; lerr_q <= 1'b0; cyc_q <= 1'b0;
        end else begin
            st_q <= st_d; ndig_q <= ndig_d; adr_q <= adr_d; dat_q <= dat_d; rdat_q <= rdat_d;
            tmo_q <= tmo_d; kind_q <= kind_d; wr_q <= wr_d; lerr_q <= lerr_d; cyc_q <= cyc_d;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q & wr_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = 4'hF;

    // ---------------- message sequencer and UART transmitter ----------------
    function automatic logic [7:0] msg_char(input logic [1:0] kind, input logic [3:0] idx,
                                            input logic [31:0] rd);
        logic [3:0] nib;
        nib = rd[{~idx[2:0], 2'b00} +: 4];
        case (kind)
            K_BANNER: return BANNER[{~idx, 3'b000} +: 8];
            K_OK:     return OK_MSG[{~idx, 3'b000} +: 8];
            K_ERR:    return ER_MSG[{~idx, 3'b000} +: 8];
            default:  return (idx == 4'd8) ? 8'h0A :
                             (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
        endcase
    endfunction

    function automatic logic msg_last(input logic [1:0] kind, input logic [3:0] idx);
        case (kind)
            K_BANNER: return idx == 4'd13;
            K_OK:     return idx == 4'd11;
            K_ERR:    return idx == 4'd5;
            default:  return idx == 4'd8;
        endcase
    endfunction

    logic [1:0]  msg_kind_q;
    logic [3:0]  msg_idx_q, tx_bit_q;
    logic [10:0] tx_sh_q;
    logic [15:0] tx_cnt_q;
    logic        tx_busy_q, tx_load;

    assign tx_load  = msg_busy_q && !tx_busy_q;
    assign uart_txd = tx_busy_q ? tx_sh_q[0] : 1'b1;

    // Banner is armed by reset itself, so it leaves as soon as reset is released
    always_ff @(posedge app_clk or negedge line_reset_n) begin
        if (!line_reset_n) begin
            msg_busy_q <= 1'b1; msg_kind_q <= K_BANNER; msg_idx_q <= '0;
            tx_busy_q <= 1'b0; tx_sh_q <= '1; tx_bit_q <= '0; tx_cnt_q <= '0;
        end else begin
            if (st_q == P_RESP && !msg_busy_q) begin
                msg_busy_q <= 1'b1; msg_kind_q <= kind_q; msg_idx_q <= '0;
            end else if (tx_load) begin
                msg_idx_q <= msg_idx_q + 4'd1;
                if (msg_last(msg_kind_q, msg_idx_q)) msg_busy_q <= 1'b0;
            end
            if (tx_load) begin
                tx_busy_q <= 1'b1;
                tx_sh_q   <= {2'b11, msg_char(msg_kind_q, msg_idx_q, rdat_q), 1'b0};
                tx_bit_q  <= '0;
                tx_cnt_q  <= '0;
            end else if (tx_busy_q) begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_q <= '0;
                    tx_sh_q  <= {1'b1, tx_sh_q[10:1]};
                    tx_bit_q <= tx_bit_q + 4'd1;
                    if (tx_bit_q == 4'd10) tx_busy_q <= 1'b0;
                end else tx_cnt_q <= tx_cnt_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_caravel_uart_wb_master.sv
// tb/tb_caravel_uart_wb_master.sv - directed bench: UART host driver, TX decoder, Wishbone slave model
`timescale 1ns/1ps
module tb_caravel_uart_wb_master;
    localparam int BAUD_DIV   = 0;
    localparam int WB_TIMEOUT = 64;
    localparam int BIT        = 16 * (BAUD_DIV + 1);

    logic        clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
    logic        txd, cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [31:0] wb_dat_i = '0;
    logic        ack = 1'b0, err = 1'b0;

    int checks = 0, errors = 0;
    int slv_mode = 0;
    int cyc_hi = 0;
    byte unsigned rx_q[$];
    logic [31:0] wr_adr_q[$], wr_dat_q[$];
    logic [3:0]  wr_sel_q[$];
    logic [31:0] mem [logic [31:0]];

    caravel_uart_wb_master #(.BAUD_DIV(BAUD_DIV), .WB_TIMEOUT(WB_TIMEOUT)) dut (
        .app_clk(clk), .line_reset_n(rst_n), .uart_rxd(rxd), .uart_txd(txd),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr), .wbm_dat_o(dat),
        .wbm_sel_o(sel), .wbm_dat_i(wb_dat_i), .wbm_ack_i(ack), .wbm_err_i(err)
    );

    always #5 clk = ~clk;

    // Wishbone slave: mode 0 acks after 2 cycles, mode 1 errors, mode 2 never answers
    initial begin
        int dly;
        dly = 0;
        forever begin
            @(negedge clk);
            if (cyc) cyc_hi++;
            if (!rst_n || !(cyc && stb)) begin
                ack = 1'b0; err = 1'b0; dly = 0;
            end else if (!ack && !err) begin
                if (slv_mode == 0) begin
                    dly++;
                    if (dly >= 2) begin
                        ack = 1'b1;
                        if (we) begin
                            mem[adr] = dat;
                            wr_adr_q.push_back(adr); wr_dat_q.push_back(dat); wr_sel_q.push_back(sel);
                        end else wb_dat_i = mem.exists(adr) ? mem[adr] : 32'hDEADBEEF;
                    end
                end else if (slv_mode == 1) err = 1'b1;
            end
        end
    end

    // UART decoder on txd, sampling mid-bit
    initial begin
        byte unsigned b;
        forever begin
            @(negedge clk);
            if (rst_n && txd === 1'b0) begin
                repeat (BIT / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    task automatic send_byte(input byte unsigned b);
        rxd = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(posedge clk);
        end
        rxd = 1'b1;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_resp(input int n, output string s);
        int t;
        t = 0;
        s = "";
        while (rx_q.size() < n && t < n * BIT * 14 + 4 * WB_TIMEOUT + 2000) begin
            @(posedge clk);
            t++;
        end
        for (int i = 0; i < n && rx_q.size() > 0; i++) s = $sformatf("%s%c", s, rx_q.pop_front());
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
        checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b want 0", cyc); end
        checks++; if (stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", stb); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
        checks++; if (adr !== 32'h0) begin errors++; $display("FAIL reset_adr got %h want 0", adr); end
        checks++; if (dat !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 0", dat); end
        checks++; if (sel !== 4'hF) begin errors++; $display("FAIL reset_sel got %h want f", sel); end
    endtask

    task automatic test_banner();
        int t, lo;
        string s;
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (txd !== 1'b0 && t < 500) begin @(negedge clk); t++; end
        checks++; if (t >= 500) begin errors++; $display("FAIL banner_start got no start bit within %0d cycles", t); end
        lo = 0;
        while (txd === 1'b0 && lo < 200) begin @(negedge clk); lo++; end
        checks++; if (lo != BIT) begin errors++; $display("FAIL banner_bit_time got %0d want %0d", lo, BIT); end
        wait_resp(14, s);
        checks++; if (s != "UART2WB ready\n") begin errors++; $display("FAIL banner_text got %s want UART2WB ready", s); end
        repeat (400) @(negedge clk);
        checks++; if (rx_q.size() != 0 || txd !== 1'b1) begin
            errors++; $display("FAIL banner_quiet got %0d extra bytes txd=%b want 0 and 1", rx_q.size(), txd);
        end
    endtask

    task automatic test_write();
        string s;
        logic [31:0] a, d;
        logic [3:0] m;
        wr_adr_q.delete(); wr_dat_q.delete(); wr_sel_q.delete();
        send_str("wm 30800000 1\n");
        wait_resp(12, s);
        checks++; if (s != "cmd success\n") begin errors++; $display("FAIL write_resp got %s want cmd success", s); end
        checks++; if (wr_adr_q.size() != 1) begin errors++; $display("FAIL write_count got %0d want 1", wr_adr_q.size()); end
        if (wr_adr_q.size() > 0) begin
            a = wr_adr_q.pop_front(); d = wr_dat_q.pop_front(); m = wr_sel_q.pop_front();
            checks++; if (a !== 32'h30800000) begin errors++; $display("FAIL write_adr got %h want 30800000", a); end
            checks++; if (d !== 32'h00000001) begin errors++; $display("FAIL write_dat got %h want 00000001", d); end
            checks++; if (m !== 4'hF) begin errors++; $display("FAIL write_sel got %h want f", m); end
        end
    endtask

    task automatic test_scratch();
        string s;
        string cmd [3] = '{"wm 30020058 11223344\n", "WM 3002005C 22334455\r\n", "wm 10 abc\n"};
        logic [31:0] ea [3] = '{32'h30020058, 32'h3002005C, 32'h00000010};
        logic [31:0] ed [3] = '{32'h11223344, 32'h22334455, 32'h00000ABC};
        string rcmd [3] = '{"rm 30020058\n", "Rm 3002005c\n", "rm 10\n"};
        string rexp [3] = '{"11223344\n", "22334455\n", "00000ABC\n"};
        wr_adr_q.delete(); wr_dat_q.delete(); wr_sel_q.delete();
        for (int i = 0; i < 3; i++) begin
            send_str(cmd[i]);
            wait_resp(12, s);
            checks++; if (s != "cmd success\n") begin errors++; $display("FAIL scratch_wr%0d_resp got %s want cmd success", i, s); end
            checks++; if (wr_adr_q.size() != 1 || wr_adr_q[0] !== ea[i] || wr_dat_q[0] !== ed[i]) begin
                errors++; $display("FAIL scratch_wr%0d_bus got n=%0d want adr %h dat %h", i, wr_adr_q.size(), ea[i], ed[i]);
            end
            wr_adr_q.delete(); wr_dat_q.delete(); wr_sel_q.delete();
        end
        for (int i = 0; i < 3; i++) begin
            send_str(rcmd[i]);
            wait_resp(9, s);
            checks++; if (s != rexp[i]) begin errors++; $display("FAIL scratch_rd%0d got %s want %s", i, s, rexp[i]); end
        end
    endtask

    task automatic test_wb_error();
        string s;
        slv_mode = 1;
        send_str("rm 30020058\n");
        wait_resp(6, s);
        checks++; if (s != "error\n") begin errors++; $display("FAIL wb_err_resp got %s want error", s); end
        slv_mode = 2;
        cyc_hi = 0;
        send_str("rm 30020058\n");
        wait_resp(6, s);
        checks++; if (s != "error\n") begin errors++; $display("FAIL wb_timeout_resp got %s want error", s); end
        checks++; if (cyc_hi != WB_TIMEOUT) begin errors++; $display("FAIL wb_timeout_len got %0d want %0d", cyc_hi, WB_TIMEOUT); end
        checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL wb_timeout_cyc got %b want 0", cyc); end
        slv_mode = 0;
    endtask

    task automatic test_bad_cmds();
        string s;
        string bad [3] = '{"xm 1\n", "wm 123456789 1\n", "rm \n"};
        wr_adr_q.delete(); wr_dat_q.delete(); wr_sel_q.delete();
        for (int i = 0; i < 3; i++) begin
            send_str(bad[i]);
            wait_resp(6, s);
            checks++; if (s != "error\n") begin errors++; $display("FAIL bad%0d_resp got %s want error", i, s); end
        end
        checks++; if (wr_adr_q.size() != 0) begin errors++; $display("FAIL bad_no_write got %0d writes want 0", wr_adr_q.size()); end
        send_str("rm 10\n");
        wait_resp(9, s);
        checks++; if (s != "00000ABC\n") begin errors++; $display("FAIL bad_recover got %s want 00000ABC", s); end
    endtask

    task automatic test_reset_mid();
        string s;
        int t;
        send_str("rm 3");
        rxd = 1'b0;
        repeat (BIT * 3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (txd !== 1'b1 || cyc !== 1'b0) begin errors++; $display("FAIL rst_rx_outputs got txd=%b cyc=%b want 1 0", txd, cyc); end
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        rx_q.delete();
        rst_n = 1'b1;
        wait_resp(14, s);
        checks++; if (s != "UART2WB ready\n") begin errors++; $display("FAIL rst_rx_banner got %s want UART2WB ready", s); end

        slv_mode = 2;
        send_str("rm 30020058\n");
        t = 0;
        while (cyc !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        checks++; if (cyc !== 1'b1) begin errors++; $display("FAIL rst_wb_cycle got cyc=%b want 1", cyc); end
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (cyc !== 1'b0 || stb !== 1'b0 || txd !== 1'b1) begin
            errors++; $display("FAIL rst_wb_outputs got cyc=%b stb=%b txd=%b want 0 0 1", cyc, stb, txd);
        end
        repeat (200) @(negedge clk);
        rx_q.delete();
        slv_mode = 0;
        rst_n = 1'b1;
        wait_resp(14, s);
        checks++; if (s != "UART2WB ready\n") begin errors++; $display("FAIL rst_wb_banner got %s want UART2WB ready", s); end
        send_str("wm 10 5\n");
        wait_resp(12, s);
        checks++; if (s != "cmd success\n") begin errors++; $display("FAIL rst_after_wr got %s want cmd success", s); end
        send_str("rm 10\n");
        wait_resp(9, s);
        checks++; if (s != "00000005\n") begin errors++; $display("FAIL rst_after_rd got %s want 00000005", s); end
    endtask

    initial begin
        test_reset();
        test_banner();
        test_write();
        test_scratch();
        test_wb_error();
        test_bad_cmds();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
